// File: rtl/pulse_to_level.sv
// Stretches single-cycle request pulses into a held level of programmable length,
// with a mandatory one-cycle low gap between holds and a flag for dropped pulses.
module pulse_to_level #(
    parameter int HOLD_W    = 8,
    parameter int RETRIGGER = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_i,
    input  logic [HOLD_W-1:0] hold_len_i,
    input  logic              ack_i,
    output logic              level_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic [CNT_W-1:0]  accept_cnt_o
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] HOLD = 2'b01;
    localparam logic [1:0] GAP  = 2'b10;

    localparam logic [HOLD_W-1:0] HOLD_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              level_q, busy_q, ovr_q, ovr_d;

    // A captured length of zero means "hold until ack"; ack always beats a same-cycle pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pulse_i) begin
                    state_d = HOLD;
                    cnt_d   = hold_len_i;
                    acc_d   = acc_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (ack_i) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    ovr_d   = pulse_i;
                end else if (pulse_i && (RETRIGGER != 0)) begin
                    cnt_d = hold_len_i;
                    acc_d = acc_q + CNT_ONE;
                end else begin
                    ovr_d = pulse_i;
                    if (cnt_q == HOLD_ONE) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - HOLD_ONE;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
                ovr_d   = pulse_i;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            level_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
            ovr_q   <= ovr_d;
        end
    end

    assign level_o      = level_q;
    assign busy_o       = busy_q;
    assign overrun_o    = ovr_q;
    assign accept_cnt_o = acc_q;

endmodule
